// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode constants and FSM state encoding for seq_alu
//                and its combinational decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // ALUcontrol opcode encoding
    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SLL = 3'b001;
    localparam logic [2:0] c_OP_SUB = 3'b010;
    localparam logic [2:0] c_OP_RSV = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SRL = 3'b101;
    localparam logic [2:0] c_OP_OR  = 3'b110;
    localparam logic [2:0] c_OP_AND = 3'b111;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // True for the two opcodes that run through the iterative shifter
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == c_OP_SLL) || (op == c_OP_SRL);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_comb_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_comb_unit
//  Description : Single-cycle ALU operations (add, sub, xor, or, and,
//                reserved). Shift opcodes produce 0 here; the sequencer
//                owns shifting.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_comb_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_result
);

    // Opcode decode; add/sub wrap naturally at WIDTH bits
    always_comb begin
        o_result = '0;
        case (i_op)
            c_OP_ADD: o_result = i_src_a + i_src_b;
            c_OP_SUB: o_result = i_src_a - i_src_b;
            c_OP_XOR: o_result = i_src_a ^ i_src_b;
            c_OP_OR:  o_result = i_src_a | i_src_b;
            c_OP_AND: o_result = i_src_a & i_src_b;
            default:  o_result = '0;
        endcase
    end

endmodule : alu_comb_unit
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Sequential ALU with valid/ready handshake. Single-cycle ops
//                complete in one edge; shifts iterate one bit per edge.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUcontrol,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_work,  w_work_nxt;
    logic [4:0]       r_cnt,   w_cnt_nxt;
    logic             r_dir,   w_dir_nxt;   // 1 = shift right
    logic             r_zero,  w_zero_nxt;

    logic [WIDTH-1:0] w_comb;
    logic [WIDTH-1:0] w_shifted;
    logic [4:0]       w_k;
    logic             w_is_shift;

    alu_comb_unit #(
        .WIDTH (WIDTH)
    ) u_comb (
        .i_src_a  (SrcA),
        .i_src_b  (SrcB),
        .i_op     (ALUcontrol),
        .o_result (w_comb)
    );

    assign w_k        = SrcB[4:0];
    assign w_is_shift = is_shift_op(ALUcontrol);
    assign w_shifted  = r_dir ? (r_work >> 1) : (r_work << 1);

    // Next-state, datapath and counter control
    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_zero_nxt  = r_zero;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (w_is_shift && (w_k != 5'd0)) begin
                        w_work_nxt  = SrcA;
                        w_cnt_nxt   = w_k;
                        w_dir_nxt   = (ALUcontrol == c_OP_SRL);
                        w_state_nxt = SHIFT;
                    end else begin
                        // A zero-length shift is a pass-through of SrcA
                        w_work_nxt  = w_is_shift ? SrcA : w_comb;
                        w_zero_nxt  = ((w_is_shift ? SrcA : w_comb) == '0);
                        w_state_nxt = DONE;
                    end
                end
            end
            SHIFT: begin
                w_work_nxt = w_shifted;
                w_cnt_nxt  = r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    w_zero_nxt  = (w_shifted == '0);
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_cnt   <= 5'd0;
            r_dir   <= 1'b0;
            r_zero  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_zero  <= w_zero_nxt;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign ALUResult = r_work;
    assign Zero      = r_zero;

endmodule : seq_alu
`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 SrcA  input  WIDTH  first operand; sampled on accept.
REQ-005 SrcB  input  WIDTH  second operand; for shifts, SrcB[4:0] is the shift amount; sampled on accept.
REQ-006 ALUcontrol  input  3  operation code; sampled on accept.
REQ-007 in_valid  input  1  the requester presents an operation.
REQ-008 in_ready  output  1  the block can accept an operation.
REQ-009 ALUResult  output  WIDTH  registered result; valid while out_valid=1.
REQ-010 Zero  output  1  registered; 1 when ALUResult==0; valid while out_valid=1.
REQ-011 out_valid  output  1  the result is available.
REQ-012 out_ready  input  1  the consumer takes the result.

Function
REQ-013 ALUcontrol encoding SHALL be: 000 add, 010 sub, 001 shift left logical, 100 xor, 101 shift right logical, 110 or, 111 and, 011 reserved (result 0).
REQ-014 Add and sub SHALL wrap modulo 2^WIDTH; sub SHALL compute SrcA - SrcB in two's complement; no carry or overflow outputs.
REQ-015 The state machine SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; an accept occurs on a rising edge where in_valid=1 and in_ready=1.
REQ-017 Non-shift op accepted at edge N: the block SHALL register the result and Zero, enter DONE, and assert out_valid after edge N (1-cycle latency).
REQ-018 Shift op with shift amount k>0: on accept, the block SHALL load the SrcA value into a working register, load k into a 5-bit counter, and enter SHIFT.
REQ-019 SHIFT: on each edge, the block SHALL shift the working register by 1 bit (zero fill) and decrement the counter; the edge on which the counter goes from 1 to 0 SHALL move the block to DONE.
REQ-020 Shift result: out_valid SHALL rise exactly k+1 edges after the accept edge.
REQ-021 Shift with k=0: the block SHALL behave as a non-shift op, with result SrcA and 1-cycle latency.
REQ-022 DONE: out_valid=1, and ALUResult and Zero SHALL stay stable until an edge with out_ready=1; that edge SHALL return the block to IDLE with out_valid=0.
REQ-023 The block SHALL NOT accept a new operation in the same cycle the result is taken; minimum issue interval is 2 cycles.
REQ-024 Input changes while in SHIFT or DONE SHALL have no effect on the operation in progress.
REQ-025 An out_ready pulse while out_valid=0 SHALL be ignored.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL enter IDLE, and the outputs SHALL take these values: in_ready=1 after the edge, out_valid=0, ALUResult=0, Zero=1, counter=0.
REQ-027 rst SHALL take priority over all other events; reset mid-SHIFT or mid-DONE SHALL discard the operation with no result delivered.

Structure
REQ-028 The ALUcontrol encoding constants and the state encoding SHALL live in the shared package alu_pkg, which the ALU decoder also uses.
REQ-029 The single-cycle operations (add, sub, xor, or, and, reserved) SHALL be implemented in one combinational sub-module, alu_comb_unit; the FSM, counter and shifter SHALL reside in seq_alu.

Verification
REQ-030 Add: accept with SrcA=0x7FFFFFFF, SrcB=1, ctrl=000 -> next cycle out_valid=1, ALUResult=0x80000000, Zero=0.
REQ-031 Sub: SrcA=5, SrcB=5, ctrl=010 -> ALUResult=0, Zero=1; then SrcA=0, SrcB=1 -> ALUResult=0xFFFFFFFF.
REQ-032 SLL: SrcA=0x1, SrcB=31, ctrl=001 -> out_valid exactly 32 edges after accept, ALUResult=0x80000000; in_ready=0 throughout.
REQ-033 SRL: SrcA=0xF0000000, SrcB=0x24 (k=4), ctrl=101 -> ALUResult=0x0F000000 after 5 edges; same op with k=0 -> result 0xF0000000 after 1 edge.
REQ-034 Backpressure and reset: hold out_ready=0 for 10 cycles -> ALUResult stable, in_ready=0; assert rst mid-SHIFT -> next cycle out_valid=0, in_ready=1, ALUResult=0.
REQ-035 Reserved code and logic ops: ctrl=011 -> ALUResult=0, Zero=1; SrcA=0xF0F0, SrcB=0xFF00 with ctrl=100/110/111 -> 0x0FF0, 0xFFF0, 0xF000.
